// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one external ALU between two
//            requesters; operands are held for SETTLE_CYCLES before capture.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [2:0]  req_cmd0,
  input  logic [2:0]  req_cmd1,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_carryout,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [2:0]  alu_command,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] c_CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  logic       r_owner;
  logic       r_lastGrant;
  logic       w_grant;
  logic       w_accept;
  logic       w_captureNow;
  logic       w_respDone;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_grant = req_valid[1];
    if (req_valid == 2'b11) begin
      w_grant = ~r_lastGrant;
    end
  end

  assign w_accept     = (r_state == IDLE) && (req_valid != 2'b00);
  assign w_captureNow = (r_state == SETTLE) && (r_cnt == 8'd0);
  assign w_respDone   = (r_state == RESP) && resp_ready[r_owner];

  assign req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_nextState = SETTLE;
      SETTLE:  if (w_captureNow) w_nextState = RESP;
      RESP:    if (w_respDone)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= 8'd0;
      r_owner       <= 1'b0;
      r_lastGrant   <= 1'b1;
      alu_operandA  <= 32'd0;
      alu_operandB  <= 32'd0;
      alu_command   <= 3'b000;
      resp_result   <= 32'd0;
      resp_carryout <= 1'b0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_operandA <= w_grant ? req_a1   : req_a0;
        alu_operandB <= w_grant ? req_b1   : req_b0;
        alu_command  <= w_grant ? req_cmd1 : req_cmd0;
        r_owner      <= w_grant;
        r_lastGrant  <= w_grant;
        r_cnt        <= c_CNT_LOAD;
      end else if (r_state == SETTLE) begin
        if (w_captureNow) begin
          resp_result   <= alu_result;
          resp_carryout <= alu_carryout;
          resp_overflow <= alu_overflow;
          resp_zero     <= (alu_result == 32'd0);
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_cmd0, req_cmd1;
  logic [31:0] resp_result, alu_operandA, alu_operandB, alu_result;
  logic        resp_carryout, resp_overflow, resp_zero;
  logic [2:0]  alu_command;
  logic        alu_carryout, alu_overflow, busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
  } aluOut_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carryout(resp_carryout),
    .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .busy(busy)
  );

  function automatic aluOut_t aluRef(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] cmd);
    aluOut_t    o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0]; o.c = s[32];
        o.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0]; o.c = s[32];
        o.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'd2: o.r = a ^ b;
      3'd3: o.r = {31'd0, ($signed(a) < $signed(b))};
      3'd4: o.r = a & b;
      3'd5: o.r = ~(a & b);
      3'd6: o.r = ~(a | b);
      default: o.r = a | b;
    endcase
    return o;
  endfunction

  function automatic exp_t mkExp(input logic who, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] cmd);
    aluOut_t o;
    o = aluRef(a, b, cmd);
    return {who, o.r, o.c, o.v, (o.r == 32'd0)};
  endfunction

  assign {alu_result, alu_carryout, alu_overflow} = aluRef(alu_operandA, alu_operandB, alu_command);

  // Presents one request for a single cycle; returns on the negedge after the accept edge.
  task automatic sendReq(input logic who, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cmd);
    @(negedge clk);
    if (who) begin req_a1 = a; req_b1 = b; req_cmd1 = cmd; end
    else     begin req_a0 = a; req_b0 = b; req_cmd0 = cmd; end
    req_valid[who] = 1'b1;
    sb.push_back(mkExp(who, a, b, cmd));
    @(negedge clk);
    req_valid[who] = 1'b0;
  endtask

  task automatic waitResp(output int lat);
    lat = 0;
    while (resp_valid == 2'b00 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_cmd0 = '0; req_cmd1 = '0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({busy, resp_valid, req_ready} !== 5'b0) begin
      nFails++; $display("FAIL reset_ctrl: got busy/rv/rr=%b expected 00000", {busy, resp_valid, req_ready});
    end
    nChecks++;
    if ({alu_operandA, alu_operandB, alu_command} !== 67'd0) begin
      nFails++; $display("FAIL reset_alu: got %h %h %b expected zeros", alu_operandA, alu_operandB, alu_command);
    end
    nChecks++;
    if ({resp_result, resp_carryout, resp_overflow, resp_zero} !== 35'd0) begin
      nFails++; $display("FAIL reset_resp: got %h %b%b%b expected zeros", resp_result, resp_carryout, resp_overflow, resp_zero);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_add();
    int   lat;
    exp_t e;
    sendReq(1'b0, 32'd5, 32'd7, 3'b000);
    nChecks++;
    if ({busy, alu_operandA, alu_command} !== {1'b1, 32'd5, 3'b000}) begin
      nFails++; $display("FAIL add_drive: got busy=%b A=%h cmd=%b expected 1 5 000", busy, alu_operandA, alu_command);
    end
    waitResp(lat);
    nChecks++;
    if (lat !== SETTLE) begin
      nFails++; $display("FAIL add_latency: got %0d expected %0d", lat, SETTLE);
    end
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero} !==
        {2'b01, 32'h0000000C, 3'b000} || e.result !== 32'h0000000C) begin
      nFails++; $display("FAIL add_payload: got rv=%b res=%h c/v/z=%b%b%b expected 01 0000000c 000",
                         resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero);
    end
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++; $display("FAIL add_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_sub_slt();
    int   lat;
    exp_t e;
    sendReq(1'b1, 32'd3, 32'd3, 3'b001);
    waitResp(lat);
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero} !==
        {2'b10, 32'd0, 1'b1, 1'b0, 1'b1} || lat !== SETTLE) begin
      nFails++; $display("FAIL sub_zero: got rv=%b res=%h c/v/z=%b%b%b lat=%0d expected 10 00000000 101 %0d",
                         resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero, lat, SETTLE);
    end
    @(negedge clk);
    sendReq(1'b1, 32'hFFFFFFFF, 32'd1, 3'b011);
    waitResp(lat);
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_zero} !== {2'b10, 32'h00000001, 1'b0} ||
        {resp_carryout, resp_overflow} !== {e.carry, e.ovf}) begin
      nFails++; $display("FAIL slt: got rv=%b res=%h z=%b expected 10 00000001 0", resp_valid, resp_result, resp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int   lat;
    exp_t e;
    sendReq(1'b0, 32'h7FFFFFFF, 32'd1, 3'b000);
    waitResp(lat);
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero} !==
        {2'b01, 32'h80000000, 1'b0, 1'b1, 1'b0} || e.ovf !== 1'b1) begin
      nFails++; $display("FAIL overflow: got rv=%b res=%h c/v/z=%b%b%b expected 01 80000000 010",
                         resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic grants[4];
    int   nGrant = 0;
    int   nResp  = 0;
    int   cyc    = 0;
    exp_t e;
    @(negedge clk);
    reset_n = 1'b0;
    req_a0 = 32'd10; req_b0 = 32'd1; req_cmd0 = 3'b000;
    req_a1 = 32'd10; req_b1 = 32'd1; req_cmd1 = 3'b001;
    req_valid = 2'b11; resp_ready = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    while (nResp < 4 && cyc < 200) begin
      #1;
      nChecks++;
      if (req_ready === 2'b11) begin
        nFails++; $display("FAIL contention_ready: got 11 expected not 11 at cycle %0d", cyc);
      end
      if (req_ready != 2'b00 && nGrant < 4) begin
        grants[nGrant] = req_ready[1];
        sb.push_back(mkExp(req_ready[1], 32'd10, 32'd1, req_ready[1] ? 3'b001 : 3'b000));
        nGrant++;
      end
      if (resp_valid != 2'b00) begin
        e = sb.pop_front();
        nChecks++;
        if ({resp_valid, resp_result, resp_zero} !== {(e.owner ? 2'b10 : 2'b01), e.result, e.zero}) begin
          nFails++; $display("FAIL contention_resp: got rv=%b res=%h expected owner=%b res=%h",
                             resp_valid, resp_result, e.owner, e.result);
        end
        nResp++;
        if (nResp == 4) req_valid = 2'b00;
      end
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (nResp !== 4 || nGrant !== 4) begin
      nFails++; $display("FAIL contention_timeout: got %0d grants %0d responses expected 4 4", nGrant, nResp);
    end
    nChecks++;
    if ({grants[0], grants[1], grants[2], grants[3]} !== 4'b0101) begin
      nFails++; $display("FAIL contention_order: got %b%b%b%b expected 0101", grants[0], grants[1], grants[2], grants[3]);
    end
    sb.delete();
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          lat;
    exp_t        e;
    logic [31:0] held;
    resp_ready = 2'b00;
    sendReq(1'b0, 32'h0000F0F0, 32'h00003C3C, 3'b100);
    req_a1 = 32'd1; req_b1 = 32'd1; req_cmd1 = 3'b000;
    req_valid[1] = 1'b1;
    waitResp(lat);
    held = resp_result;
    nChecks++;
    if (lat !== SETTLE) begin
      nFails++; $display("FAIL bp_latency: got %0d expected %0d", lat, SETTLE);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nChecks++;
      if ({resp_valid, resp_result, busy, req_ready} !== {2'b01, held, 1'b1, 2'b00}) begin
        nFails++; $display("FAIL bp_stall: got rv=%b res=%h busy=%b rr=%b expected 01 %h 1 00",
                           resp_valid, resp_result, busy, req_ready, held);
      end
    end
    resp_ready = 2'b10;
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero} !==
        {2'b01, e.result, e.carry, e.ovf, e.zero}) begin
      nFails++; $display("FAIL bp_other_ready: got rv=%b res=%h expected 01 %h", resp_valid, resp_result, e.result);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    nChecks++;
    if ({busy, req_ready} !== 3'b010) begin
      nFails++; $display("FAIL bp_release: got busy=%b rr=%b expected 0 10", busy, req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++; $display("FAIL bp_drop: got busy=%b expected 0", busy);
    end
    resp_ready = 2'b11;
  endtask

  task automatic test_reset_mid_op();
    int   lat;
    int   seen = 0;
    exp_t e;
    sendReq(1'b0, 32'h0000AAAA, 32'h00005555, 3'b111);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    nChecks++;
    if ({busy, resp_valid, req_ready, alu_operandA, alu_operandB, alu_command,
         resp_result, resp_carryout, resp_overflow, resp_zero} !== '0) begin
      nFails++; $display("FAIL midreset_values: got busy=%b rv=%b A=%h B=%h cmd=%b res=%h expected all zero",
                         busy, resp_valid, alu_operandA, alu_operandB, alu_command, resp_result);
    end
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen++;
    end
    nChecks++;
    if (seen !== 0) begin
      nFails++; $display("FAIL midreset_noresp: got %0d cycles with resp_valid expected 0", seen);
    end
    sendReq(1'b0, 32'd9, 32'd4, 3'b001);
    waitResp(lat);
    e = sb.pop_front();
    nChecks++;
    if ({resp_valid, resp_result, resp_carryout, resp_overflow, resp_zero} !==
        {2'b01, 32'd5, 1'b1, 1'b0, 1'b0} || lat !== SETTLE || e.result !== 32'd5) begin
      nFails++; $display("FAIL midreset_next: got rv=%b res=%h lat=%0d expected 01 00000005 %0d",
                         resp_valid, resp_result, lat, SETTLE);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_slt();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
